// File: rtl/conv_encoder_pkg.sv
// conv_encoder_pkg
// Shared constants for the K=7 convolutional encoder: code-rate encodings,
// generator polynomials, puncture period lengths and keep masks, FSM state
// type, and a parity helper that applies a generator to the shift register.
package conv_encoder_pkg;

    // cc_rate encodings
    typedef enum logic [1:0] {
        Rate12 = 2'd0,
        Rate23 = 2'd1,
        Rate34 = 2'd2,
        Rate56 = 2'd3
    } rate_id_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StTail,
        StDrain
    } enc_state_e;

    // Generator polynomials; MSB is the tap at delay 0 (the current input).
    localparam logic [6:0] GEN_X = 7'o171;
    localparam logic [6:0] GEN_Y = 7'o133;

    localparam int unsigned PHASE_W = 3;

    // Indexed by rate id. Period = number of encoder inputs per puncture period.
    localparam logic [3:0][PHASE_W-1:0] PERIOD_LEN = {3'd5, 3'd3, 3'd2, 3'd1};

    // Bit p set = keep that output at phase p (X is always emitted before Y).
    //   1/2: X1Y1   2/3: X1Y1Y2   3/4: X1Y1Y2X3   5/6: X1Y1Y2X3Y4X5
    localparam logic [3:0][7:0] KEEP_X_MASK = {8'b0001_0101, 8'b0000_0101,
                                               8'b0000_0001, 8'b0000_0001};
    localparam logic [3:0][7:0] KEEP_Y_MASK = {8'b0000_1011, 8'b0000_0011,
                                               8'b0000_0011, 8'b0000_0001};

    // Parity of the generator taps over {current input, sr[0] .. sr[5]}.
    function automatic logic gen_parity(input logic [6:0] gen, input logic b,
                                        input logic [5:0] sr);
        logic [6:0] win;
        win = {b, sr[0], sr[1], sr[2], sr[3], sr[4], sr[5]};
        return ^(win & gen);
    endfunction

endpackage

// File: rtl/cc_punct_lut.sv
// cc_punct_lut
// Combinational puncture lookup for the convolutional encoder.
// Ports:
//   rate       in   code rate id (0=1/2, 1=2/3, 2=3/4, 3=5/6)
//   phase      in   puncture phase of the input being encoded
//   keep_x     out  emit the X output for this input
//   keep_y     out  emit the Y output for this input
//   period_end out  this phase is the last one of the puncture period
module cc_punct_lut
    import conv_encoder_pkg::*;
(
    input  logic [1:0]         rate,
    input  logic [PHASE_W-1:0] phase,
    output logic               keep_x,
    output logic               keep_y,
    output logic               period_end
);

    always_comb begin
        keep_x     = KEEP_X_MASK[rate][phase];
        keep_y     = KEEP_Y_MASK[rate][phase];
        period_end = (phase == PERIOD_LEN[rate] - 3'd1);
    end

endmodule

// File: rtl/conv_encoder.sv
// conv_encoder
// K=7 (171/133 octal) convolutional encoder with puncturing to 1/2, 2/3,
// 3/4 or 5/6, emitting one coded bit per transfer. Each burst is flushed
// with TAIL_LEN zero inputs so every burst ends in the zero state.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_bit/in_valid/in_last/in_ready   uncoded input stream
//   cc_rate             code rate, latched on the first bit of a burst
//   out_bit/out_valid/out_last/out_ready  punctured coded output stream
module conv_encoder
    import conv_encoder_pkg::*;
#(
    parameter int unsigned TAIL_LEN = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic [1:0] cc_rate,
    output logic       out_bit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);

    localparam int unsigned TCNT_W = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

    enc_state_e         state_q, state_d;
    logic [5:0]         sr_q, sr_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [1:0]         rate_q, rate_d;
    logic [TCNT_W-1:0]  tail_cnt_q, tail_cnt_d;
    // Pending register: entry 0 is the head presented on out_bit.
    logic [1:0]         pend_cnt_q, pend_cnt_d;
    logic [1:0]         pend_bit_q, pend_bit_d;
    logic [1:0]         pend_last_q, pend_last_d;

    logic       out_fire;
    logic       room;
    logic       in_fire;
    logic       tail_step;
    logic       enc_step;
    logic       enc_in;
    logic [1:0] eff_rate;
    logic       keep_x;
    logic       keep_y;
    logic       period_end;
    logic       code_x;
    logic       code_y;
    logic       last_tail;
    logic       final_in;

    // The first bit of a burst is encoded with the live cc_rate; later bits
    // use the value latched with it.
    assign eff_rate = (state_q == StIdle) ? cc_rate : rate_q;

    cc_punct_lut u_punct_lut (
        .rate       (eff_rate),
        .phase      (phase_q),
        .keep_x     (keep_x),
        .keep_y     (keep_y),
        .period_end (period_end)
    );

    always_comb begin
        out_valid = (pend_cnt_q != 2'd0);
        out_bit   = pend_bit_q[0];
        out_last  = pend_last_q[0];
        out_fire  = out_valid & out_ready;

        // A new input may load only if the pending register is empty or its
        // single remaining bit leaves this cycle.
        room      = (pend_cnt_q == 2'd0) || ((pend_cnt_q == 2'd1) && out_ready);
        in_ready  = ((state_q == StIdle) || (state_q == StRun)) && room;
        in_fire   = in_ready & in_valid;
        tail_step = (state_q == StTail) && room;
        enc_step  = in_fire | tail_step;
        enc_in    = in_fire ? in_bit : 1'b0;

        code_x    = gen_parity(GEN_X, enc_in, sr_q);
        code_y    = gen_parity(GEN_Y, enc_in, sr_q);

        last_tail = (tail_cnt_q == TCNT_W'(TAIL_LEN - 1));
        final_in  = (tail_step && last_tail) ||
                    (in_fire && in_last && (TAIL_LEN == 0));
    end

    // Datapath next state: shift register, phase and pending register.
    always_comb begin
        sr_d        = sr_q;
        phase_d     = phase_q;
        pend_cnt_d  = pend_cnt_q;
        pend_bit_d  = pend_bit_q;
        pend_last_d = pend_last_q;

        if (enc_step) begin
            sr_d    = {sr_q[4:0], enc_in};
            phase_d = period_end ? '0 : phase_q + 3'd1;
            // Loading is only allowed when the head is free, so new bits
            // always land at entry 0.
            if (keep_x && keep_y) begin
                pend_bit_d  = {code_y, code_x};
                pend_last_d = {final_in, 1'b0};
                pend_cnt_d  = 2'd2;
            end else if (keep_x) begin
                pend_bit_d  = {1'b0, code_x};
                pend_last_d = {1'b0, final_in};
                pend_cnt_d  = 2'd1;
            end else begin
                pend_bit_d  = {1'b0, code_y};
                pend_last_d = {1'b0, final_in};
                pend_cnt_d  = 2'd1;
            end
        end else if (out_fire) begin
            pend_bit_d  = {1'b0, pend_bit_q[1]};
            pend_last_d = {1'b0, pend_last_q[1]};
            pend_cnt_d  = pend_cnt_q - 2'd1;
        end

        // Returning to IDLE restarts the code from the zero state.
        if ((state_q == StDrain) && out_fire && out_last) begin
            sr_d    = '0;
            phase_d = '0;
        end
    end

    // Control FSM.
    always_comb begin
        state_d    = state_q;
        rate_d     = rate_q;
        tail_cnt_d = tail_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (in_fire) begin
                    rate_d     = cc_rate;
                    tail_cnt_d = '0;
                    if (in_last) begin
                        state_d = (TAIL_LEN == 0) ? StDrain : StTail;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (in_fire && in_last) begin
                    tail_cnt_d = '0;
                    state_d    = (TAIL_LEN == 0) ? StDrain : StTail;
                end
            end
            StTail: begin
                if (tail_step) begin
                    if (last_tail) begin
                        state_d = StDrain;
                    end else begin
                        tail_cnt_d = tail_cnt_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (out_fire && out_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            phase_q     <= '0;
            rate_q      <= '0;
            tail_cnt_q  <= '0;
            pend_cnt_q  <= '0;
            pend_bit_q  <= '0;
            pend_last_q <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            phase_q     <= phase_d;
            rate_q      <= rate_d;
            tail_cnt_q  <= tail_cnt_d;
            pend_cnt_q  <= pend_cnt_d;
            pend_bit_q  <= pend_bit_d;
            pend_last_q <= pend_last_d;
        end
    end

endmodule
